// File: rtl/riscv_dmem_resp_pkg.sv
// Shared constants for the RV32I data-memory responder.
// Holds the FSM state encoding, the funct3 codes for loads and stores,
// and small helpers that classify a request as illegal or misaligned.
package riscv_dmem_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    // Loads only define 0/1/2/4/5; stores only define 0/1/2.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we) return (f3 > F3_SW);
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

    // funct3[1:0] gives the access size for every legal code (LBU/LHU included).
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        if (f3[1:0] == 2'd1) return off[0];
        if (f3[1:0] == 2'd2) return (off != 2'd0);
        return 1'b0;
    endfunction

endpackage

// File: rtl/riscv_dmem_resp_if.sv
// Request/response bus between a core (master) and the data-memory
// responder (slave).
// Both channels use valid/ready: a transfer happens on a rising edge where
// valid and ready are both 1; the sender holds its payload stable while
// valid is high and ready is low.
//   req_*  : core -> responder request (we, byte address, funct3, store data)
//   rsp_*  : responder -> core response (load data, error flag)
interface riscv_dmem_resp_if #(parameter int ADDR_W = 15);

    logic              req_valid_in;
    logic              req_ready_out;
    logic              req_we_in;
    logic [ADDR_W-1:0] req_addr_in;
    logic [2:0]        req_funct3_in;
    logic [31:0]       req_wdata_in;
    logic              rsp_valid_out;
    logic              rsp_ready_in;
    logic [31:0]       rsp_rdata_out;
    logic              rsp_err_out;

    modport master (
        output req_valid_in, req_we_in, req_addr_in, req_funct3_in, req_wdata_in,
        output rsp_ready_in,
        input  req_ready_out, rsp_valid_out, rsp_rdata_out, rsp_err_out
    );

    modport slave (
        input  req_valid_in, req_we_in, req_addr_in, req_funct3_in, req_wdata_in,
        input  rsp_ready_in,
        output req_ready_out, rsp_valid_out, rsp_rdata_out, rsp_err_out
    );

endinterface

// File: rtl/riscv_dmem_lane.sv
// Byte-lane steering for RV32I loads and stores (purely combinational).
//   byte_off_in : addr[1:0] of the access
//   funct3_in   : RV32I size/sign code
//   wdata_in    : LSB-aligned store data (rs2)
//   rword_in    : memory word being read
//   be_out      : byte enables for a store (0 for non-store codes)
//   wdata_out   : store data replicated onto every lane
//   rdata_out   : extracted and extended load data (0 for non-load codes)
// Alignment is not checked here; the caller masks misaligned accesses.
module riscv_dmem_lane
    import riscv_dmem_resp_pkg::*;
(
    input  logic [1:0]  byte_off_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rword_in,
    output logic [3:0]  be_out,
    output logic [31:0] wdata_out,
    output logic [31:0] rdata_out
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rword_in >> {byte_off_in, 3'b000};
        rdata_out = '0;
        case (funct3_in)
            F3_LB:   rdata_out = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   rdata_out = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   rdata_out = shifted;
            F3_LBU:  rdata_out = {24'h0, shifted[7:0]};
            F3_LHU:  rdata_out = {16'h0, shifted[15:0]};
            default: rdata_out = '0;
        endcase
    end

    // Replicating the data means the enables alone pick the lane.
    always_comb begin
        be_out    = 4'b0000;
        wdata_out = wdata_in;
        case (funct3_in)
            F3_SB: begin
                be_out    = 4'b0001 << byte_off_in;
                wdata_out = {4{wdata_in[7:0]}};
            end
            F3_SH: begin
                be_out    = 4'b0011 << byte_off_in;
                wdata_out = {2{wdata_in[15:0]}};
            end
            F3_SW: begin
                be_out    = 4'b1111;
                wdata_out = wdata_in;
            end
            default: begin
                be_out    = 4'b0000;
                wdata_out = wdata_in;
            end
        endcase
    end

endmodule

// File: rtl/riscv_dmem_resp.sv
// Data-memory responder for an RV32I core.
// Accepts one load/store, waits WAIT_CYC cycles, then holds a response
// until the core takes it. Stores commit and loads sample memory on the
// edge entering RESP. Misaligned, out-of-range or illegal-funct3 requests
// answer with rsp_err_out=1, rdata 0 and no write.
//   clk, reset    : clock, asynchronous active-low reset
//   bus           : request/response channels (slave side)
//   state_dbg_out : current FSM state
module riscv_dmem_resp
    import riscv_dmem_resp_pkg::*;
#(
    parameter int ADDR_W      = 15,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYC    = 2
) (
    input  logic             clk,
    input  logic             reset,
    riscv_dmem_resp_if.slave bus,
    output state_e           state_dbg_out
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0]       mem [DEPTH_WORDS];

    logic              req_ready;
    logic              accept, enter_resp, rsp_done, in_idle;
    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [2:0]        cur_f3;
    logic [31:0]       cur_wdata;
    logic [31:0]       word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              req_err;
    logic              mem_we;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata, lane_rdata, rword;

    assign in_idle    = (state_q == ST_IDLE);
    assign accept     = bus.req_valid_in && req_ready;
    assign rsp_done   = (state_q == ST_RESP) && bus.rsp_ready_in;
    assign enter_resp = (in_idle && accept && (WAIT_CYC == 0)) ||
                        ((state_q == ST_WAIT) && (cnt_q == 4'd0));

    // With WAIT_CYC=0 the request enters RESP on its own accept edge, so the
    // live inputs stand in for the not-yet-captured registers in IDLE.
    assign cur_we    = in_idle ? bus.req_we_in     : we_q;
    assign cur_addr  = in_idle ? bus.req_addr_in   : addr_q;
    assign cur_f3    = in_idle ? bus.req_funct3_in : f3_q;
    assign cur_wdata = in_idle ? bus.req_wdata_in  : wdata_q;

    assign word_idx = 32'(cur_addr[ADDR_W-1:2]);
    assign mem_idx  = cur_addr[IDX_W+1:2];
    assign req_err  = (word_idx >= 32'(DEPTH_WORDS)) ||
                      f3_illegal(cur_we, cur_f3) ||
                      misaligned(cur_f3, cur_addr[1:0]);
    assign rword    = mem[mem_idx];
    assign mem_we   = enter_resp && cur_we && !req_err;

    riscv_dmem_lane u_lane (
        .byte_off_in (cur_addr[1:0]),
        .funct3_in   (cur_f3),
        .wdata_in    (cur_wdata),
        .rword_in    (rword),
        .be_out      (lane_be),
        .wdata_out   (lane_wdata),
        .rdata_out   (lane_rdata)
    );

    // State register and captured request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            f3_q    <= 3'd0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is not reset; an aborted store never reaches this edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_be[b]) mem[mem_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_CYC == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_RESP: begin
                if (bus.rsp_ready_in) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request capture and response registers.
    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            we_d    = bus.req_we_in;
            addr_d  = bus.req_addr_in;
            f3_d    = bus.req_funct3_in;
            wdata_d = bus.req_wdata_in;
        end
        if (enter_resp) begin
            rdata_d = (cur_we || req_err) ? 32'h0 : lane_rdata;
            err_d   = req_err;
        end else if (rsp_done) begin
            rdata_d = 32'h0;
            err_d   = 1'b0;
        end
    end

    // Outputs; ready is gated by reset so it stays low while reset is held.
    always_comb begin
        req_ready         = in_idle && reset;
        bus.req_ready_out = req_ready;
        bus.rsp_valid_out = (state_q == ST_RESP);
        bus.rsp_rdata_out = rdata_q;
        bus.rsp_err_out   = err_q;
        state_dbg_out     = state_q;
    end

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// Bench for riscv_dmem_resp: directed and random load/store traffic against
// a word-array model, plus a WAIT_CYC=0 instance for throughput.
module tb_riscv_dmem_resp;
    import riscv_dmem_resp_pkg::*;

    localparam int AW = 15;
    localparam int WA = 2;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [2:0]    f3;
        logic [31:0]   wdata;
    } req_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    riscv_dmem_resp_if #(.ADDR_W(AW)) bus_a ();
    riscv_dmem_resp_if #(.ADDR_W(AW)) bus_b ();
    state_e state_a, state_b;

    riscv_dmem_resp #(.ADDR_W(AW), .DEPTH_WORDS(1024), .WAIT_CYC(WA)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave), .state_dbg_out(state_a)
    );
    riscv_dmem_resp #(.ADDR_W(AW), .DEPTH_WORDS(1024), .WAIT_CYC(0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave), .state_dbg_out(state_b)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    int rsp_cnt = 0;
    int acc_cyc = 0;
    int last_lat = 0;
    int rdy_mode = 0;  // 0: always ready, 1: random, 2: hold off
    logic [32:0] last_rsp = '0;
    logic [32:0] exp_q[$];
    req_t        pend_q[$];
    logic [31:0] mm [int];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural model: byte-addressed memory built from 32-bit words.
    function automatic logic [32:0] model_rsp(input req_t r);
        int w, off, sz, sh;
        logic [31:0] v, mask;
        bit err;
        w   = int'(r.addr) >> 2;
        off = int'(r.addr) & 3;
        sz  = int'(r.f3) & 3;
        err = (w >= 1024);
        if (r.we) err |= (r.f3 > 3'd2);
        else      err |= (r.f3 == 3'd3 || r.f3 >= 3'd6);
        if (sz == 1 && (off % 2) != 0) err = 1;
        if (sz == 2 && off != 0) err = 1;
        if (err) return {1'b1, 32'h0};
        sh = 8 * off;
        mask = (sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
        if (r.we) begin
            mm[w] = (mm[w] & ~(mask << sh)) | ((r.wdata & mask) << sh);
            return 33'h0;
        end
        v = (mm[w] >> sh) & mask;
        if (r.f3 == 3'd0 && v >= 32'h80)   v = v | 32'hFFFF_FF00;
        if (r.f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        return {1'b0, v};
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_ready", bus_a.req_ready_out, 0);
            chk("rst_valid", bus_a.rsp_valid_out, 0);
            chk("rst_err",   bus_a.rsp_err_out, 0);
            chk("rst_rdata", bus_a.rsp_rdata_out, 0);
            chk("rst_state", state_a, ST_IDLE);
            pend_q.delete();
            exp_q.delete();
        end else if (pend_q.size() != 0 && cyc >= acc_cyc + WA + 1) begin
            if (exp_q.size() == 0) begin
                exp_q.push_back(model_rsp(pend_q[0]));
                last_lat = cyc - acc_cyc;
            end
            chk("rsp_valid", bus_a.rsp_valid_out, 1);
            chk("rsp_data", {bus_a.rsp_err_out, bus_a.rsp_rdata_out}, exp_q[0]);
            chk("busy_ready", bus_a.req_ready_out, 0);
            if (bus_a.rsp_ready_in) begin
                last_rsp = exp_q.pop_front();
                pend_q.delete(0);
                rsp_cnt++;
            end
        end else begin
            chk("early_valid", bus_a.rsp_valid_out, 0);
            chk("req_ready", bus_a.req_ready_out, pend_q.size() == 0);
            if (bus_a.req_valid_in && bus_a.req_ready_out) begin
                pend_q.push_back({bus_a.req_we_in, bus_a.req_addr_in,
                                  bus_a.req_funct3_in, bus_a.req_wdata_in});
                acc_cyc = cyc;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus_a.rsp_ready_in = 1'b1;
            1:       bus_a.rsp_ready_in = 1'($urandom_range(0, 1));
            default: bus_a.rsp_ready_in = 1'b0;
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic we, input logic [AW-1:0] addr,
                         input logic [2:0] f3, input logic [31:0] wdata);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        bus_a.req_valid_in  = 1'b1;
        bus_a.req_we_in     = we;
        bus_a.req_addr_in   = addr;
        bus_a.req_funct3_in = f3;
        bus_a.req_wdata_in  = wdata;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus_a.req_ready_out) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk); #1;
        bus_a.req_valid_in = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic do_txn(input logic we, input logic [AW-1:0] addr,
                          input logic [2:0] f3, input logic [31:0] wdata);
        int n;
        n = rsp_cnt;
        issue(we, addr, f3, wdata);
        for (int i = 0; i < 200 && rsp_cnt == n; i++) @(posedge clk);
        if (rsp_cnt == n) chk("rsp_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n, accepts;
        logic [AW-1:0] ra;
        bus_a.req_valid_in = 0; bus_a.req_we_in = 0; bus_a.req_addr_in = '0;
        bus_a.req_funct3_in = 0; bus_a.req_wdata_in = 0; bus_a.rsp_ready_in = 1;
        bus_b.req_valid_in = 0; bus_b.req_we_in = 0; bus_b.req_addr_in = '0;
        bus_b.req_funct3_in = 0; bus_b.req_wdata_in = 0; bus_b.rsp_ready_in = 1;

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", bus_a.req_ready_out, 1);

        // Known contents for the words random traffic will touch.
        for (int w = 0; w < 16; w++) do_txn(1, AW'(4 * w), F3_SW, $urandom);

        do_txn(1, 15'h0010, F3_SW, 32'hDEADBEEF);
        chk("sw_err", last_rsp, 33'h0);
        chk("sw_latency", last_lat, 3);
        do_txn(0, 15'h0010, F3_LW, 0);
        chk("lw_deadbeef", last_rsp, {1'b0, 32'hDEADBEEF});

        do_txn(1, 15'h0010, F3_SW, 32'h11223344);
        do_txn(1, 15'h0013, F3_SB, 32'h00000080);
        do_txn(0, 15'h0010, F3_LW, 0);
        chk("sb_merge", last_rsp, {1'b0, 32'h80223344});
        do_txn(0, 15'h0013, F3_LB, 0);
        chk("lb_sign", last_rsp, {1'b0, 32'hFFFFFF80});
        do_txn(0, 15'h0013, F3_LBU, 0);
        chk("lbu_zero", last_rsp, {1'b0, 32'h00000080});

        do_txn(0, 15'h0012, F3_LW, 0);
        chk("lw_misalign", last_rsp, {1'b1, 32'h0});
        do_txn(1, 15'h0011, F3_SH, 32'h0000AAAA);
        chk("sh_misalign", last_rsp, {1'b1, 32'h0});
        do_txn(0, 15'h1000, F3_LW, 0);
        chk("out_of_range", last_rsp, {1'b1, 32'h0});
        do_txn(0, 15'h0010, F3_LW, 0);
        chk("no_write_on_err", last_rsp, {1'b0, 32'h80223344});

        // Backpressure: response held, a new request is refused.
        rdy_mode = 2;
        n = rsp_cnt;
        issue(0, 15'h0010, F3_LW, 0);
        for (int i = 0; i < 20 && !bus_a.rsp_valid_out; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus_a.req_valid_in = 1'b1;
            bus_a.req_we_in = 1'b1;
            bus_a.req_addr_in = 15'h0004;
            bus_a.req_funct3_in = F3_SW;
            @(negedge clk);
            chk("bp_ready", bus_a.req_ready_out, 0);
            chk("bp_valid", bus_a.rsp_valid_out, 1);
            chk("bp_rdata", bus_a.rsp_rdata_out, 32'h80223344);
        end
        @(posedge clk); #1;
        bus_a.req_valid_in = 1'b0;
        @(negedge clk);
        rdy_mode = 0;
        for (int i = 0; i < 20 && rsp_cnt == n; i++) @(posedge clk);
        chk("bp_one_rsp", rsp_cnt, n + 1);

        // Reset during WAIT discards the store.
        do_txn(1, 15'h0020, F3_SW, 32'h12345678);
        n = rsp_cnt;
        issue(1, 15'h0020, F3_SW, 32'hCAFEF00D);
        @(negedge clk);
        chk("abort_in_wait", state_a, ST_WAIT);
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_ready", bus_a.req_ready_out, 1);
        chk("abort_no_rsp", rsp_cnt, n);
        do_txn(0, 15'h0020, F3_LW, 0);
        chk("abort_old_value", last_rsp, {1'b0, 32'h12345678});

        // Random traffic.
        for (int t = 0; t < 150; t++) begin
            rdy_mode = $urandom_range(0, 1);
            if ($urandom_range(0, 4) == 0) ra = AW'($urandom_range(16'h1000, 16'h7FFF));
            else                           ra = AW'($urandom_range(0, 63));
            do_txn(1'($urandom_range(0, 1)), ra, 3'($urandom_range(0, 7)), $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        rdy_mode = 0;
        repeat (3) @(posedge clk);

        // WAIT_CYC=0 instance: valid held high, one accept every two cycles.
        accepts = 0;
        @(posedge clk); #1;
        bus_b.req_we_in = 1'b1;
        bus_b.req_addr_in = 15'h0004;
        bus_b.req_funct3_in = F3_SW;
        bus_b.req_wdata_in = 32'h0BADF00D;
        bus_b.req_valid_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("b_ready", bus_b.req_ready_out, (i % 2) == 0);
            chk("b_valid", bus_b.rsp_valid_out, (i % 2) == 1);
            chk("b_state", state_b, ((i % 2) == 1) ? ST_RESP : ST_IDLE);
            if (bus_b.rsp_valid_out) chk("b_rsp", {bus_b.rsp_err_out, bus_b.rsp_rdata_out}, 33'h0);
            if (bus_b.req_valid_in && bus_b.req_ready_out) accepts++;
        end
        chk("b_accepts", accepts, 10);
        @(posedge clk); #1;
        bus_b.req_valid_in = 1'b0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_dmem_resp.md
RISCV_DMEM_RESP -- requirements
Module: riscv_dmem_resp

Interface
REQ-001 Parameter ADDR_W, default 15, byte-address width of the data port.
REQ-002 Parameter DEPTH_WORDS, default 1024, number of 32-bit words stored.
REQ-003 Parameter WAIT_CYC, default 2, wait states between request accept and response (0..15).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_valid_in  input  1  core presents a load/store request.
REQ-007 req_ready_out  output  1  responder can accept a request this cycle.
REQ-008 req_we_in  input  1  1 = store, 0 = load.
REQ-009 req_addr_in  input  ADDR_W  byte address, the ALU result.
REQ-010 req_funct3_in  input  3  RV32I size/sign code, inst[14:12].
REQ-011 req_wdata_in  input  32  store data, rs2, LSB-aligned.
REQ-012 rsp_valid_out  output  1  response available.
REQ-013 rsp_ready_in  input  1  core accepts the response.
REQ-014 rsp_rdata_out  output  32  load data, extended per funct3; 0 for stores and errors.
REQ-015 rsp_err_out  output  1  misaligned, out-of-range or illegal-funct3 access.

Function
REQ-016 The block SHALL implement FSM states IDLE, WAIT and RESP.
REQ-017 In IDLE: req_ready_out=1; a handshake (req_valid_in & req_ready_out) captures we, addr, funct3 and wdata, then moves to WAIT (or RESP if WAIT_CYC=0).
REQ-018 In WAIT: a 4-bit counter loads WAIT_CYC-1 on accept and decrements each cycle; at 0 the state moves to RESP.
REQ-019 In WAIT and RESP, req_ready_out SHALL be 0; req_* inputs are ignored.
REQ-020 In RESP: rsp_valid_out=1 and rsp_rdata_out/rsp_err_out stay stable until rsp_ready_in=1; that cycle returns the FSM to IDLE.
REQ-021 No back-to-back accept: the earliest next accept is the cycle after the response handshake.
REQ-022 Request-to-response latency SHALL be WAIT_CYC+1 cycles from the accept edge.
REQ-023 Loads, funct3 0/1/2/4/5 = LB/LH/LW/LBU/LHU: select the byte/halfword lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-024 Stores, funct3 0/1/2 = SB/SH/SW: write only the addressed byte lanes from wdata[7:0]/[15:0]/[31:0]; other lanes are unchanged.
REQ-025 The error condition is any of the following:
- halfword access with addr[0]=1;
- word access with addr[1:0]!=0;
- addr[ADDR_W-1:2] >= DEPTH_WORDS;
- load funct3 3/6/7;
- store funct3 3..7.
REQ-026 On error: no memory write, rsp_rdata_out=0, rsp_err_out=1, with normal handshake timing.
REQ-027 The store write SHALL commit on the edge entering RESP, so a load accepted after the response reads the new data.
REQ-028 Loads SHALL sample memory on the edge entering RESP.

Reset
REQ-029 On reset low: FSM=IDLE, counter=0, req_ready_out=0 while reset is asserted, rsp_valid_out=0, rsp_rdata_out=0, rsp_err_out=0.
REQ-030 Reset asserted mid-transaction SHALL abort it: an uncommitted store is discarded and no response is issued.
REQ-031 Memory array contents SHALL NOT be reset.
REQ-032 req_ready_out SHALL rise in the first cycle after reset deasserts.

Structure
REQ-033 A shared constants file SHALL hold:
- FSM state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
- funct3 codes for LB/LH/LW/LBU/LHU/SB/SH/SW.
REQ-034 One sub-module, riscv_dmem_lane (combinational), SHALL compute store byte-enables/shifted data and load extraction/extension from addr[1:0] and funct3.
REQ-035 The storage SHALL be a synchronous-write word array inside riscv_dmem_resp; there is no other hierarchy.

Verification
REQ-036 SW addr 0x0010 wdata 0xDEADBEEF, WAIT_CYC=2 -> rsp_valid_out high exactly 3 cycles after accept, err=0; then LW 0x0010 -> rdata 0xDEADBEEF.
REQ-037 Byte lanes:
- SB addr 0x0013 wdata 0x80 over 0x11223344 -> LW 0x0010 returns 0x80223344;
- LB 0x0013 -> 0xFFFFFF80;
- LBU 0x0013 -> 0x00000080.
REQ-038 Misaligned and out-of-range:
- LW 0x0012 -> err=1, rdata 0, memory unchanged;
- SH 0x0011 -> err=1, no write;
- addr 0x1000 with DEPTH_WORDS=1024 -> err=1.
REQ-039 Backpressure: hold rsp_ready_in=0 for 5 cycles -> rsp_valid_out/rdata stable; req_ready_out stays 0; a req_valid_in pulse is not accepted.
REQ-040 Reset mid-WAIT of SW 0x0020 0xCAFEF00D -> no response; LW 0x0020 after reset returns the prior value.
REQ-041 WAIT_CYC=0 -> response 1 cycle after accept; back-to-back requests with rsp_ready_in tied 1 -> one accept every 2 cycles.
